// File: rtl/regfile_pkg.sv
// Shared register-file constants, writeback requester indices and arbiter state type.
package regfile_pkg;

    localparam int unsigned REG_AW = 5;
    localparam int unsigned REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_ZERO = 5'd0;

    localparam int unsigned WB_ALU = 0;
    localparam int unsigned WB_MEM = 1;
    localparam int unsigned WB_DBG = 2;

    typedef enum logic [0:0] {
        WB_IDLE,
        WB_COMMIT
    } wb_state_e;

    // Index width for an n-way selector; never zero so a 1-requester build still elaborates.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback requester bundle plus the register-file write port driven by the arbiter.
interface regfile_wb_arbiter_if
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = REG_AW,
    parameter int unsigned DW   = REG_DW,
    parameter int unsigned CW   = 16
) ();

    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_data;
    logic [NREQ-1:0]    gnt;
    logic               rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [DW-1:0]      rf_wdata;
    logic [2**AW-1:0]   pending_mask;
    logic               x0_drop;
    logic [CW-1:0]      wr_count;

    // Requester side
    modport master (
        output req, req_addr, req_data,
        input  gnt, rf_we, rf_waddr, rf_wdata, pending_mask, x0_drop, wr_count
    );

    // Arbiter side
    modport slave (
        input  req, req_addr, req_data,
        output gnt, rf_we, rf_waddr, rf_wdata, pending_mask, x0_drop, wr_count
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first asserted request after ptr_i, wrapping modulo NREQ.
module rr_pick
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned PW   = ptr_width(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [NREQ-1:0] winner_o,
    output logic            valid_o
);

    logic [PW-1:0] idx;

    always_comb begin
        winner_o = '0;
        valid_o  = 1'b0;
        idx      = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            idx = PW'((32'(ptr_i) + k) % NREQ);
            if (!valid_o && req_i[idx]) begin
                winner_o[idx] = 1'b1;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file's single write port among writeback sources.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ = 3,
    parameter int unsigned AW   = REG_AW,
    parameter int unsigned DW   = REG_DW,
    parameter int unsigned CW   = 16
) (
    input logic              clk,
    input logic              rst,
    regfile_wb_arbiter_if.slave bus
);

    localparam int unsigned PW = ptr_width(NREQ);

    wb_state_e        state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
    logic             rf_we_q, rf_we_d;
    logic [AW-1:0]    rf_waddr_q, rf_waddr_d;
    logic [DW-1:0]    rf_wdata_q, rf_wdata_d;
    logic             x0_drop_q, x0_drop_d;
    logic [CW-1:0]    wr_count_q, wr_count_d;

    logic [NREQ-1:0]  winner;
    logic             valid;
    logic [PW-1:0]    win_idx;
    logic [AW-1:0]    win_addr;
    logic [DW-1:0]    win_data;
    logic [2**AW-1:0] pending_mask;

    rr_pick #(
        .NREQ (NREQ),
        .PW   (PW)
    ) u_rr_pick (
        .req_i    (bus.req),
        .ptr_i    (rr_ptr_q),
        .winner_o (winner),
        .valid_o  (valid)
    );

    always_comb begin
        win_idx  = '0;
        win_addr = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (winner[i]) begin
                win_idx  = PW'(i);
                win_addr = bus.req_addr[i*AW +: AW];
                win_data = bus.req_data[i*DW +: DW];
            end
        end
    end

    // A granted request keeps its bit until the requester drops req.
    always_comb begin
        pending_mask = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (bus.req[i]) begin
                pending_mask[bus.req_addr[i*AW +: AW]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WB_IDLE;
            gnt_q      <= '0;
            rr_ptr_q   <= PW'(NREQ - 1);
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            x0_drop_q  <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
            x0_drop_q  <= x0_drop_d;
            wr_count_q <= wr_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE:   if (valid) state_d = WB_COMMIT;
            WB_COMMIT: state_d = WB_IDLE;
            default:   state_d = WB_IDLE;
        endcase
    end

    // Pulses last exactly the COMMIT cycle; address/data stay put for the file's falling edge.
    always_comb begin
        gnt_d      = '0;
        rf_we_d    = 1'b0;
        x0_drop_d  = 1'b0;
        rr_ptr_d   = rr_ptr_q;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        wr_count_d = wr_count_q;
        if (state_q == WB_IDLE && valid) begin
            gnt_d      = winner;
            rr_ptr_d   = win_idx;
            rf_waddr_d = win_addr;
            rf_wdata_d = win_data;
            if (win_addr != AW'(REG_ZERO)) begin
                rf_we_d    = 1'b1;
                wr_count_d = wr_count_q + CW'(1);
            end else begin
                x0_drop_d  = 1'b1;
            end
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.rf_we        = rf_we_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.x0_drop      = x0_drop_q;
    assign bus.wr_count     = wr_count_q;
    assign bus.pending_mask = pending_mask;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed cases plus random requesters checked against a
// behavioural arbitration model and a shadow register file.
module tb_regfile_wb_arbiter;
    import regfile_pkg::*;

    localparam int unsigned NREQ = 3;
    localparam int unsigned AW   = 5;
    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) bus ();

    regfile_wb_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Behavioural model state
    int              m_ptr   = NREQ - 1;
    bit              m_busy  = 1'b0;
    logic [NREQ-1:0] e_gnt   = '0;
    logic            e_we    = 1'b0;
    logic            e_x0    = 1'b0;
    logic [AW-1:0]   e_waddr = '0;
    logic [DW-1:0]   e_wdata = '0;
    logic [CW-1:0]   e_count = '0;
    logic [DW-1:0]   m_rf [32] = '{default: '0};
    logic [DW-1:0]   d_rf [32] = '{default: '0};

    function automatic logic [31:0] exp_pending();
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < NREQ; i++)
            if (bus.req[i]) m = m | (32'd1 << bus.req_addr[i*AW +: AW]);
        return m;
    endfunction

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_ptr = NREQ - 1; m_busy = 1'b0; e_gnt = '0; e_we = 1'b0; e_x0 = 1'b0;
            e_waddr = '0; e_wdata = '0; e_count = '0;
        end else if (m_busy) begin
            m_busy = 1'b0; e_gnt = '0; e_we = 1'b0; e_x0 = 1'b0;
        end else begin
            int w;
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                int j;
                j = (m_ptr + k) % NREQ;
                if (w < 0 && bus.req[j]) w = j;
            end
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_ptr   = w;
                e_gnt   = NREQ'(1 << w);
                e_waddr = bus.req_addr[w*AW +: AW];
                e_wdata = bus.req_data[w*DW +: DW];
                e_we    = (e_waddr != 0);
                e_x0    = (e_waddr == 0);
                if (e_we) e_count = e_count + 1'b1;
            end
        end
    end

    // Compare on the falling edge, which is also where the register file commits.
    initial forever begin
        @(negedge clk);
        check("gnt", bus.gnt, e_gnt);
        check("rf_we", bus.rf_we, e_we);
        check("rf_waddr", bus.rf_waddr, e_waddr);
        check("rf_wdata", bus.rf_wdata, e_wdata);
        check("x0_drop", bus.x0_drop, e_x0);
        check("wr_count", bus.wr_count, e_count);
        check("pending_mask", bus.pending_mask, exp_pending());
        if (e_we) m_rf[e_waddr] = e_wdata;
        if (bus.rf_we === 1'b1) d_rf[bus.rf_waddr] = bus.rf_wdata;
    end

    task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req[i]                = 1'b1;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_data[i*DW +: DW]  = d;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int order[$];

    initial begin
        rst = 1'b1;
        bus.req = '0;
        bus.req_addr = '0;
        bus.req_data = '0;
        tick(); tick();
        check("rst_gnt", bus.gnt, 0);
        check("rst_we", bus.rf_we, 0);
        check("rst_waddr", bus.rf_waddr, 0);
        check("rst_wdata", bus.rf_wdata, 0);
        check("rst_x0", bus.x0_drop, 0);
        check("rst_count", bus.wr_count, 0);
        rst = 1'b0;

        // Single write from ALU
        tick();
        set_req(WB_ALU, 5'd5, 32'h0000ABCD);
        tick();
        check("w1_gnt", bus.gnt, 3'b001);
        check("w1_we", bus.rf_we, 1);
        check("w1_waddr", bus.rf_waddr, 5);
        check("w1_wdata", bus.rf_wdata, 32'h0000ABCD);
        check("w1_count", bus.wr_count, 1);
        bus.req[WB_ALU] = 1'b0;
        tick();
        check("w1_idle_gnt", bus.gnt, 0);
        check("w1_idle_we", bus.rf_we, 0);
        check("w1_hold_waddr", bus.rf_waddr, 5);

        // Write to x0 is discarded
        set_req(WB_MEM, 5'd0, 32'hFFFFFFFF);
        tick();
        check("x0_gnt", bus.gnt, 3'b010);
        check("x0_drop", bus.x0_drop, 1);
        check("x0_we", bus.rf_we, 0);
        check("x0_count", bus.wr_count, 1);
        bus.req[WB_MEM] = 1'b0;
        tick();

        // pending_mask ahead of any grant; both withdraw before the next edge
        set_req(WB_ALU, 5'd3, 32'h1);
        set_req(WB_MEM, 5'd9, 32'h2);
        #1;
        check("pending_lit", bus.pending_mask, 32'h00000208);
        bus.req = '0;
        tick();

        // Bring rr_ptr to 0, then race ALU and DEBUG to register 7
        set_req(WB_ALU, 5'd1, 32'h1);
        tick();
        bus.req[WB_ALU] = 1'b0;
        tick();
        set_req(WB_ALU, 5'd7, 32'h11);
        set_req(WB_DBG, 5'd7, 32'h22);
        order.delete();
        for (int c = 0; c < 10 && bus.req != 0; c++) begin
            tick();
            for (int i = 0; i < NREQ; i++)
                if (bus.gnt[i]) begin order.push_back(i); bus.req[i] = 1'b0; end
        end
        check("race_n", order.size(), 2);
        if (order.size() == 2) begin
            check("race_first", order[0], WB_DBG);
            check("race_second", order[1], WB_ALU);
        end
        check("race_wdata", bus.rf_wdata, 32'h11);
        tick();
        check("race_rf7", d_rf[7], 32'h11);

        // Round-robin from reset with all three requesting continuously
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(WB_ALU, 5'd10, $urandom);
        set_req(WB_MEM, 5'd11, $urandom);
        set_req(WB_DBG, 5'd12, $urandom);
        order.delete();
        repeat (12) begin
            tick();
            for (int i = 0; i < NREQ; i++)
                if (bus.gnt[i]) begin
                    order.push_back(i);
                    bus.req_data[i*DW +: DW] = $urandom;
                end
        end
        bus.req = '0;
        check("rr_n", order.size(), 6);
        foreach (order[k]) check("rr_order", order[k], k % 3);
        check("rr_count", bus.wr_count, 6);

        // Reset during COMMIT; re-arbitration restarts at requester 0
        set_req(WB_MEM, 5'd4, 32'hDEAD);
        tick();
        check("mr_gnt", bus.gnt, 3'b010);
        #2 rst = 1'b1;
        #1;
        check("mr_rst_gnt", bus.gnt, 0);
        check("mr_rst_we", bus.rf_we, 0);
        check("mr_rst_count", bus.wr_count, 0);
        set_req(WB_DBG, 5'd6, 32'hBEEF);
        #2 rst = 1'b0;
        tick();
        check("mr_first_gnt", bus.gnt, 3'b010);

        // Random requesters obeying the handshake
        repeat (3000) begin
            tick();
            for (int i = 0; i < NREQ; i++) begin
                if (bus.gnt[i]) begin
                    if ($urandom_range(1, 0) == 1)
                        set_req(i, AW'($urandom_range(7, 0)), $urandom);
                    else
                        bus.req[i] = 1'b0;
                end else if (bus.req[i]) begin
                    if ($urandom_range(15, 0) == 0) bus.req[i] = 1'b0;
                end else if ($urandom_range(2, 0) == 0) begin
                    set_req(i, AW'($urandom_range(7, 0)), $urandom);
                end
            end
        end
        bus.req = '0;
        repeat (3) tick();
        for (int k = 0; k < 32; k++) check("rf_final", d_rf[k], m_rf[k]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
